// File: rtl/mem_arbiter_pkg.sv
// Shared widths and types for the fetch/data memory arbiter.
package mem_arbiter_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int STRB_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   typedef struct packed {
      logic [STRB_W-1:0] wstrb;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } bus_req_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Two-way round-robin selector: a lone requester wins, on contention the
// master that was not granted last wins.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_idx,
   output logic       grant_valid
);

   always_comb begin
      grant_valid = |req;
      grant_idx   = 1'b0;
      case (req)
         2'b01:   grant_idx = 1'b0;
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = ~last_grant;
         default: grant_idx = 1'b0;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch (m0) and load/store (m1) with
// round-robin fairness and a response timeout that completes with an error.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_valid,
   input  logic [STRB_W-1:0] m0_wstrb,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_ready,
   output logic              m0_err,
   input  logic              m1_valid,
   input  logic [STRB_W-1:0] m1_wstrb,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_ready,
   output logic              m1_err,
   output logic              s_valid,
   output logic [STRB_W-1:0] s_wstrb,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic              s_ready
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

   state_t            state;
   state_t            state_next;
   logic              last_grant;
   logic [CNT_W-1:0]  cnt;
   bus_req_t          req_q;
   bus_req_t          req_pick;
   logic [DATA_W-1:0] m0_rdata_q;
   logic [DATA_W-1:0] m1_rdata_q;
   logic              grant_idx;
   logic              grant_valid;
   logic              load;
   logic              done;
   logic              timed_out;

   rr_pick2 u_pick (
      .req         ({m1_valid, m0_valid}),
      .last_grant  (last_grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always_comb begin
      req_pick.wstrb = m0_wstrb;
      req_pick.addr  = m0_addr;
      req_pick.wdata = m0_wdata;
      if (grant_idx) begin
         req_pick.wstrb = m1_wstrb;
         req_pick.addr  = m1_addr;
         req_pick.wdata = m1_wdata;
      end
   end

   // A grant always ends in IDLE, whether by s_ready or by timeout.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      done       = 1'b0;
      timed_out  = 1'b0;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               load       = 1'b1;
               state_next = grant_idx ? GNT1 : GNT0;
            end
         end
         GNT0, GNT1: begin
            if (s_ready) begin
               done       = 1'b1;
               state_next = IDLE;
            end else if (cnt == CNT_LAST) begin
               done       = 1'b1;
               timed_out  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Completion is gated by rst so a reset in a response cycle stays silent.
   always_comb begin
      m0_ready = rst && done && (state == GNT0);
      m1_ready = rst && done && (state == GNT1);
      m0_err   = m0_ready && timed_out;
      m1_err   = m1_ready && timed_out;
      m0_rdata = m0_rdata_q;
      m1_rdata = m1_rdata_q;
      if (m0_ready) m0_rdata = timed_out ? '0 : s_rdata;
      if (m1_ready) m1_rdata = timed_out ? '0 : s_rdata;
   end

   assign s_valid = (state != IDLE);
   assign s_wstrb = req_q.wstrb;
   assign s_addr  = req_q.addr;
   assign s_wdata = req_q.wdata;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // last_grant resets to m1 so that m0 wins the first contention.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_grant <= 1'b1;
         cnt        <= '0;
         req_q      <= '0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         if (load) begin
            req_q      <= req_pick;
            last_grant <= grant_idx;
         end
         if (state == IDLE || done) begin
            cnt <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (m0_ready) m0_rdata_q <= m0_rdata;
         if (m1_ready) m1_rdata_q <= m1_rdata;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: expected transfers are queued as
// they are requested and retired against the slave bus and ready pulses.
module tb_mem_arbiter;

   localparam int TIMEOUT = 16;

   typedef struct packed {
      logic        who;
      logic [1:0]  wstrb;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      logic        err;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_valid, m1_valid;
   logic [1:0]  m0_wstrb, m1_wstrb;
   logic [15:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [15:0] m0_rdata, m1_rdata;
   logic        m0_ready, m1_ready, m0_err, m1_err;
   logic        s_valid;
   logic [1:0]  s_wstrb;
   logic [15:0] s_addr, s_wdata, s_rdata;
   logic        s_ready;

   txn_t        exp_q[$];
   int          ready_cycles[$];
   int          n_vec = 0;
   int          n_miss = 0;
   int          cycle = 0;
   int          grant_run = 0;
   int          last_run = 0;
   int          ready_count = 0;
   int          slave_age = 0;
   int          slave_lat = 1;
   logic        slave_en = 1'b1;
   logic        stray_ready = 1'b0;
   logic [15:0] slave_key = 16'h0000;
   int          first;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .rst      (rst),
      .m0_valid (m0_valid),
      .m0_wstrb (m0_wstrb),
      .m0_addr  (m0_addr),
      .m0_wdata (m0_wdata),
      .m0_rdata (m0_rdata),
      .m0_ready (m0_ready),
      .m0_err   (m0_err),
      .m1_valid (m1_valid),
      .m1_wstrb (m1_wstrb),
      .m1_addr  (m1_addr),
      .m1_wdata (m1_wdata),
      .m1_rdata (m1_rdata),
      .m1_ready (m1_ready),
      .m1_err   (m1_err),
      .s_valid  (s_valid),
      .s_wstrb  (s_wstrb),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_rdata  (s_rdata),
      .s_ready  (s_ready)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pushTxn(input logic who, input logic [15:0] addr, input logic [1:0] wstrb,
                          input logic [15:0] wdata, input logic err);
      txn_t t;
      t.who   = who;
      t.addr  = addr;
      t.wstrb = wstrb;
      t.wdata = wdata;
      t.err   = err;
      t.rdata = err ? 16'h0000 : (addr ^ slave_key);
      exp_q.push_back(t);
   endtask

   // Head of the queue is the transfer that should currently own the bus.
   task automatic scoreboard();
      txn_t e;
      if (s_valid === 1'b1) begin
         grant_run++;
         if (exp_q.size() == 0) begin
            checkOutput("grant_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q[0];
            checkOutput("grant_addr", 32'(s_addr), 32'(e.addr));
            checkOutput("grant_wstrb", 32'(s_wstrb), 32'(e.wstrb));
            checkOutput("grant_wdata", 32'(s_wdata), 32'(e.wdata));
         end
      end else begin
         grant_run = 0;
      end
      if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
         last_run = grant_run;
         ready_cycles.push_back(cycle);
         ready_count++;
         if (exp_q.size() == 0) begin
            checkOutput("ready_unexpected", 32'({m1_ready, m0_ready}), 32'd0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("ready_who", 32'({m1_ready, m0_ready}), e.who ? 32'd2 : 32'd1);
            checkOutput("ready_rdata", 32'(e.who ? m1_rdata : m0_rdata), 32'(e.rdata));
            checkOutput("ready_err", 32'({m1_err, m0_err}),
                        e.who ? 32'({e.err, 1'b0}) : 32'({1'b0, e.err}));
         end
      end else begin
         checkOutput("idle_err", 32'({m1_err, m0_err}), 32'd0);
      end
   endtask

   // One cycle: slave model reacts at the falling edge, outputs sampled 1 later.
   task automatic applyStimulus();
      @(negedge clk);
      cycle++;
      if (s_valid === 1'b1) slave_age++;
      else slave_age = 0;
      s_ready = stray_ready | (slave_en & (s_valid === 1'b1) & (slave_age == slave_lat + 1));
      s_rdata = s_ready ? (s_addr ^ slave_key) : 16'hDEAD;
      #1;
      scoreboard();
   endtask

   task automatic waitReadies(input string tag, input int n, input int budget);
      int target;
      int spent;
      target = ready_count + n;
      spent  = 0;
      while (ready_count < target && spent < budget) begin
         applyStimulus();
         spent++;
      end
      checkOutput({tag, "_ready_seen"}, 32'(ready_count >= target), 32'd1);
   endtask

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: observed no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst      = 1'b0;
      m0_valid = 1'b0; m0_wstrb = 2'b00; m0_addr = 16'h0000; m0_wdata = 16'h0000;
      m1_valid = 1'b0; m1_wstrb = 2'b00; m1_addr = 16'h0000; m1_wdata = 16'h0000;
      s_ready  = 1'b0; s_rdata = 16'h0000;

      $display("[TB] reset and idle");
      applyStimulus();
      applyStimulus();
      checkOutput("reset_s_ctrl", 32'({s_valid, s_wstrb}), 32'd0);
      checkOutput("reset_s_addr", 32'(s_addr), 32'd0);
      checkOutput("reset_s_wdata", 32'(s_wdata), 32'd0);
      checkOutput("reset_m_flags", 32'({m1_err, m1_ready, m0_err, m0_ready}), 32'd0);
      checkOutput("reset_m0_rdata", 32'(m0_rdata), 32'd0);
      checkOutput("reset_m1_rdata", 32'(m1_rdata), 32'd0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput("idle_s_valid", 32'(s_valid), 32'd0);
      end

      $display("[TB] m0 single read");
      slave_key = 16'hBEFF;
      m0_valid = 1'b1; m0_addr = 16'h0010; m0_wstrb = 2'b00; m0_wdata = 16'h0000;
      pushTxn(1'b0, 16'h0010, 2'b00, 16'h0000, 1'b0);
      applyStimulus();
      checkOutput("t2_s_valid", 32'(s_valid), 32'd1);
      checkOutput("t2_s_addr", 32'(s_addr), 32'h0010);
      waitReadies("t2", 1, 6);
      checkOutput("t2_latency", 32'(last_run), 32'd2);
      checkOutput("t2_rdata", 32'(m0_rdata), 32'hBEEF);
      m0_valid = 1'b0;
      applyStimulus();
      checkOutput("t2_rdata_hold", 32'(m0_rdata), 32'hBEEF);
      checkOutput("t2_ready_drop", 32'({m1_ready, m0_ready}), 32'd0);

      $display("[TB] contention, four transfers");
      rst = 1'b0;
      applyStimulus();
      applyStimulus();
      rst = 1'b1;
      slave_key = 16'h1111;
      m0_valid = 1'b1; m0_addr = 16'h0002; m0_wstrb = 2'b00; m0_wdata = 16'h0000;
      m1_valid = 1'b1; m1_addr = 16'h0100; m1_wstrb = 2'b11; m1_wdata = 16'h1234;
      for (int i = 0; i < 2; i++) begin
         pushTxn(1'b0, 16'h0002, 2'b00, 16'h0000, 1'b0);
         pushTxn(1'b1, 16'h0100, 2'b11, 16'h1234, 1'b0);
      end
      first = ready_cycles.size();
      waitReadies("t3", 4, 20);
      m0_valid = 1'b0;
      m1_valid = 1'b0;
      if (ready_cycles.size() >= first + 4) begin
         for (int i = 1; i < 4; i++) begin
            checkOutput("t3_spacing", 32'(ready_cycles[first+i] - ready_cycles[first+i-1]), 32'd3);
         end
      end
      applyStimulus();

      $display("[TB] field change after grant");
      slave_lat = 4;
      m1_valid = 1'b1; m1_addr = 16'h0200; m1_wstrb = 2'b01; m1_wdata = 16'h00AA;
      pushTxn(1'b1, 16'h0200, 2'b01, 16'h00AA, 1'b0);
      applyStimulus();
      checkOutput("t4_s_addr", 32'(s_addr), 32'h0200);
      m1_addr = 16'h0FFF; m1_wstrb = 2'b10; m1_wdata = 16'hFFFF;
      applyStimulus();
      checkOutput("t4_s_addr_held", 32'(s_addr), 32'h0200);
      checkOutput("t4_s_wdata_held", 32'(s_wdata), 32'h00AA);
      waitReadies("t4", 1, 10);
      checkOutput("t4_latency", 32'(last_run), 32'd5);
      m1_valid = 1'b0;
      applyStimulus();

      $display("[TB] timeout and stray response");
      slave_lat = 1;
      slave_en  = 1'b0;
      m0_valid = 1'b1; m0_addr = 16'h0040; m0_wstrb = 2'b00; m0_wdata = 16'h0000;
      pushTxn(1'b0, 16'h0040, 2'b00, 16'h0000, 1'b1);
      applyStimulus();
      waitReadies("t5", 1, TIMEOUT + 4);
      checkOutput("t5_grant_cycles", 32'(last_run), 32'(TIMEOUT));
      checkOutput("t5_err", 32'({m0_err, m0_ready}), 32'd3);
      checkOutput("t5_rdata", 32'(m0_rdata), 32'd0);
      m0_valid = 1'b0;
      applyStimulus();
      checkOutput("t5_s_valid_drop", 32'(s_valid), 32'd0);
      checkOutput("t5_rdata_hold", 32'(m0_rdata), 32'd0);
      slave_en    = 1'b1;
      stray_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         applyStimulus();
         checkOutput("t5_stray_ready", 32'({m1_ready, m0_ready}), 32'd0);
         checkOutput("t5_stray_s_valid", 32'(s_valid), 32'd0);
      end
      stray_ready = 1'b0;
      applyStimulus();

      $display("[TB] reset mid-transfer");
      slave_key = 16'h2222;
      m0_valid = 1'b1; m0_addr = 16'h0080; m0_wstrb = 2'b00; m0_wdata = 16'h0000;
      pushTxn(1'b0, 16'h0080, 2'b00, 16'h0000, 1'b0);
      applyStimulus();
      checkOutput("t6_s_valid", 32'(s_valid), 32'd1);
      rst = 1'b0;
      m0_valid = 1'b0;
      applyStimulus();
      checkOutput("t6_s_valid_abort", 32'(s_valid), 32'd0);
      checkOutput("t6_no_ready", 32'({m1_ready, m0_ready}), 32'd0);
      exp_q.delete();
      rst = 1'b1;
      m0_valid = 1'b1; m0_addr = 16'h0002; m0_wstrb = 2'b00; m0_wdata = 16'h0000;
      m1_valid = 1'b1; m1_addr = 16'h0100; m1_wstrb = 2'b11; m1_wdata = 16'h1234;
      pushTxn(1'b0, 16'h0002, 2'b00, 16'h0000, 1'b0);
      pushTxn(1'b1, 16'h0100, 2'b11, 16'h1234, 1'b0);
      waitReadies("t6", 2, 12);
      m0_valid = 1'b0;
      m1_valid = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
